// File: rtl/alu_op_sequencer.sv
// Single-command sequencer around a combinational 4-bit ALU: issue, capture, hold result.
// Define ALU_SEQ_STATS_EN to add the op_count completed-operation counter output.
module alu_op_sequencer #(
    parameter int FLAG_CHECK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_greater,
    input  logic       alu_less,
    input  logic       alu_equal,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [2:0] res_flags,
    output logic [1:0] res_sel,
    output logic       res_err,
    output logic       busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [7:0] op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [1:0] alu_sel_q, alu_sel_d;
    logic [7:0] res_data_q, res_data_d;
    logic [2:0] res_flags_q, res_flags_d;
    logic [1:0] res_sel_q, res_sel_d;
    logic       res_err_q, res_err_d;

    // A comparator is healthy only when exactly one of {greater,less,equal} is set.
    function automatic logic flags_bad(input logic [2:0] f);
        logic onehot;
        onehot = (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
        return (FLAG_CHECK != 0) ? !onehot : 1'b0;
    endfunction

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        res_sel_d   = res_sel_q;
        res_err_d   = res_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    state_d   = ISSUE;
                end
            end
            // ALU inputs settle for a full cycle before the result is sampled.
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                res_data_d  = alu_out;
                res_flags_d = {alu_greater, alu_less, alu_equal};
                res_sel_d   = alu_sel_q;
                res_err_d   = flags_bad({alu_greater, alu_less, alu_equal});
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_sel_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            res_sel_q   <= res_sel_d;
            res_err_q   <= res_err_d;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [7:0] op_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if ((state_q == HOLD) && res_ready) begin
            op_count_q <= op_count_q + 8'd1;
        end
    end

    assign op_count = op_count_q;
`endif

    // Ready depends only on state and reset, never on the result handshake.
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign res_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_data  = res_data_q;
    assign res_flags = res_flags_q;
    assign res_sel   = res_sel_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU plus a second instance with FLAG_CHECK=0.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, res_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [1:0] cmd_sel;
    logic [7:0] alu_out;
    logic       alu_greater, alu_less, alu_equal;

    logic       cmd_ready, res_valid, res_err, busy;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_sel, res_sel;
    logic [7:0] res_data;
    logic [2:0] res_flags;

    logic       n_cmd_ready, n_res_valid, n_res_err, n_busy;
    logic [3:0] n_alu_a, n_alu_b;
    logic [1:0] n_alu_sel, n_res_sel;
    logic [7:0] n_res_data;
    logic [2:0] n_res_flags;
`ifdef ALU_SEQ_STATS_EN
    logic [7:0] op_count, n_op_count;
`endif

    logic       force_en;
    logic [2:0] force_flags;
    logic [2:0] mflags;

    int total = 0;
    int bad   = 0;
    int exp_ops = 0;

    always #5 clk = ~clk;

    // Reference ALU: zero-extended add/sub/mul, compare returns the flag bits.
    function automatic logic [2:0] model_flags(input logic [3:0] a, input logic [3:0] b);
        return {a > b, a < b, a == b};
    endfunction

    function automatic logic [7:0] model_out(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] s, input logic [2:0] f);
        int ia, ib;
        ia = a;
        ib = b;
        case (s)
            2'b00:   return 8'(ia + ib);
            2'b01:   return 8'(ia - ib);
            2'b10:   return 8'(ia * ib);
            default: return {5'b0, f};
        endcase
    endfunction

    assign mflags = force_en ? force_flags : model_flags(alu_a, alu_b);
    assign {alu_greater, alu_less, alu_equal} = mflags;
    assign alu_out = model_out(alu_a, alu_b, alu_sel, mflags);

    alu_op_sequencer #(.FLAG_CHECK(1)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_greater(alu_greater), .alu_less(alu_less), .alu_equal(alu_equal),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .res_sel(res_sel), .res_err(res_err), .busy(busy)
`ifdef ALU_SEQ_STATS_EN
        , .op_count(op_count)
`endif
    );

    alu_op_sequencer #(.FLAG_CHECK(0)) u_dut_nochk (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(n_alu_a), .alu_b(n_alu_b), .alu_sel(n_alu_sel),
        .alu_out(alu_out), .alu_greater(alu_greater), .alu_less(alu_less), .alu_equal(alu_equal),
        .res_valid(n_res_valid), .res_ready(res_ready), .res_data(n_res_data),
        .res_flags(n_res_flags), .res_sel(n_res_sel), .res_err(n_res_err), .busy(n_busy)
`ifdef ALU_SEQ_STATS_EN
        , .op_count(n_op_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge (the accept edge N) and withdraw it.
    task automatic accept(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_op();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_ops++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({res_valid, busy, res_data, res_flags, res_sel, res_err, alu_a, alu_b, alu_sel} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                     {res_valid, busy, res_data, res_flags, res_sel, res_err, alu_a, alu_b, alu_sel});
        end
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b required=0", cmd_ready); end
`ifdef ALU_SEQ_STATS_EN
        total++;
        if (op_count !== 8'd0) begin bad++; $display("FAIL reset_op_count got=%0d required=0", op_count); end
`endif
        rst = 1'b0;
        exp_ops = 0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL release_cmd_ready got=%b required=1", cmd_ready); end
    endtask

    task automatic test_add();
        accept(4'd5, 4'd3, 2'b00);
        total++;
        if ({busy, alu_a, alu_b, alu_sel, res_valid} !== {1'b1, 4'd5, 4'd3, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL add_issue got=%h required=%h", {busy, alu_a, alu_b, alu_sel, res_valid},
                     {1'b1, 4'd5, 4'd3, 2'b00, 1'b0});
        end
        tick();
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b required=0", res_valid); end
        tick();
        total++;
        if ({res_valid, res_data, res_sel, res_flags, res_err} !== {1'b1, 8'h08, 2'b00, 3'b100, 1'b0}) begin
            bad++;
            $display("FAIL add_result got=%h required=%h", {res_valid, res_data, res_sel, res_flags, res_err},
                     {1'b1, 8'h08, 2'b00, 3'b100, 1'b0});
        end
        finish_op();
        total++;
        if ({res_valid, cmd_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL add_after_hs got=%b required=010", {res_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_hold();
        accept(4'd4, 4'd3, 2'b10);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            cmd_sel   = 2'($urandom);
            tick();
            total++;
            if ({res_valid, res_data, res_sel, cmd_ready, alu_a, alu_b, alu_sel} !==
                {1'b1, 8'h0C, 2'b10, 1'b0, 4'd4, 4'd3, 2'b10}) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got=%h required=%h", i,
                         {res_valid, res_data, res_sel, cmd_ready, alu_a, alu_b, alu_sel},
                         {1'b1, 8'h0C, 2'b10, 1'b0, 4'd4, 4'd3, 2'b10});
            end
        end
        cmd_valid = 1'b0;
        finish_op();
        total++;
        if ({res_valid, cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL hold_release got=%b required=01", {res_valid, cmd_ready});
        end
    endtask

    task automatic test_compare();
        accept(4'd7, 4'd7, 2'b11);
        tick();
        tick();
        total++;
        if ({res_valid, res_flags, res_data, res_err, res_sel} !== {1'b1, 3'b001, 8'h01, 1'b0, 2'b11}) begin
            bad++;
            $display("FAIL compare_eq got=%h required=%h", {res_valid, res_flags, res_data, res_err, res_sel},
                     {1'b1, 3'b001, 8'h01, 1'b0, 2'b11});
        end
        finish_op();
    endtask

    task automatic test_flag_err();
        logic [2:0] pats [2];
        pats[0] = 3'b110;
        pats[1] = 3'b000;
        force_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            force_flags = pats[i];
            accept(4'd2, 4'd9, 2'b00);
            tick();
            tick();
            total++;
            if ({res_flags, res_err, res_data} !== {pats[i], 1'b1, 8'h0B}) begin
                bad++;
                $display("FAIL flag_err_chk got=%h required=%h", {res_flags, res_err, res_data},
                         {pats[i], 1'b1, 8'h0B});
            end
            total++;
            if ({n_res_valid, n_res_flags, n_res_err} !== {1'b1, pats[i], 1'b0}) begin
                bad++;
                $display("FAIL flag_err_nochk got=%h required=%h", {n_res_valid, n_res_flags, n_res_err},
                         {1'b1, pats[i], 1'b0});
            end
            finish_op();
        end
        force_en = 1'b0;
    endtask

    task automatic test_reset_abort();
        for (int k = 0; k < 2; k++) begin
            accept(4'd9, 4'd2, 2'b01);
            if (k == 1) begin
                tick();
                tick();
                res_ready = 1'b1;
            end
            rst = 1'b1;
            tick();
            res_ready = 1'b0;
            total++;
            if ({res_valid, busy, res_data, res_flags, res_sel, res_err, alu_a, alu_b, alu_sel} !== '0) begin
                bad++;
                $display("FAIL abort_outputs k=%0d got=%h required=0", k,
                         {res_valid, busy, res_data, res_flags, res_sel, res_err, alu_a, alu_b, alu_sel});
            end
`ifdef ALU_SEQ_STATS_EN
            total++;
            if (op_count !== 8'd0) begin bad++; $display("FAIL abort_op_count got=%0d required=0", op_count); end
`endif
            rst = 1'b0;
            exp_ops = 0;
            #1;
            total++;
            if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready k=%0d got=%b required=1", k, cmd_ready); end
            for (int i = 0; i < 4; i++) begin
                tick();
                total++;
                if (res_valid !== 1'b0) begin bad++; $display("FAIL abort_ghost k=%0d got=%b required=0", k, res_valid); end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        logic [1:0] s;
        logic [2:0] f;
        logic [7:0] d;
        int lat;
        for (int n = 0; n < 40; n++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            s = 2'($urandom);
            force_en = ($urandom_range(0, 3) == 0);
            force_flags = 3'($urandom);
            f = force_en ? force_flags : model_flags(a, b);
            d = model_out(a, b, s, f);
            repeat ($urandom_range(0, 2)) tick();
            accept(a, b, s);
            lat = 0;
            while (res_valid !== 1'b1 && lat < 8) begin
                tick();
                lat++;
            end
            total++;
            if (lat !== 2) begin bad++; $display("FAIL rnd_latency n=%0d got=%0d required=2", n, lat); end
            total++;
            if ({res_data, res_flags, res_sel, res_err, n_res_err, n_res_data} !==
                {d, f, s, ($countones(f) != 1), 1'b0, d}) begin
                bad++;
                $display("FAIL rnd_result n=%0d got=%h required=%h", n,
                         {res_data, res_flags, res_sel, res_err, n_res_err, n_res_data},
                         {d, f, s, ($countones(f) != 1), 1'b0, d});
            end
            repeat ($urandom_range(0, 3)) begin
                cmd_valid = $urandom_range(0, 1) == 1;
                cmd_a = 4'($urandom);
                tick();
                total++;
                if ({res_valid, res_data, cmd_ready, alu_a} !== {1'b1, d, 1'b0, a}) begin
                    bad++;
                    $display("FAIL rnd_stall n=%0d got=%h required=%h", n,
                             {res_valid, res_data, cmd_ready, alu_a}, {1'b1, d, 1'b0, a});
                end
            end
            cmd_valid = 1'b0;
            finish_op();
            total++;
            if ({res_valid, cmd_ready} !== 2'b01) begin
                bad++;
                $display("FAIL rnd_release n=%0d got=%b required=01", n, {res_valid, cmd_ready});
            end
        end
        force_en = 1'b0;
`ifdef ALU_SEQ_STATS_EN
        total++;
        if (op_count !== 8'(exp_ops)) begin
            bad++;
            $display("FAIL rnd_op_count got=%0d required=%0d", op_count, exp_ops % 256);
        end
`endif
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ops = 0;
        for (int i = 0; i < 257; i++) begin
            accept(4'($urandom), 4'($urandom), 2'($urandom));
            tick();
            tick();
            finish_op();
            if (i == 255) begin
                total++;
                if (op_count !== 8'd0) begin bad++; $display("FAIL stats_wrap got=%0d required=0", op_count); end
            end
        end
        total++;
        if (op_count !== 8'd1) begin bad++; $display("FAIL stats_257 got=%0d required=1", op_count); end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        res_ready   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_sel     = '0;
        force_en    = 1'b0;
        force_flags = '0;
        test_reset();
        test_add();
        test_hold();
        test_compare();
        test_flag_err();
        test_reset_abort();
        test_random();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
